stddev_sqrt_iter: RTL and testbench

- Multi-cycle integer square-root stage that takes the window variance term (576·Σx² − (Σx)²) produced by the window statistics stage and returns the window standard deviation used to normalise feature thresholds.
- It replaces the single-cycle combinational root with a 2-bits-per-cycle restoring algorithm, shortening the critical path.
- It uses a valid/ready handshake on both sides and carries a window tag through unchanged so the cascade evaluator can match each result to its scan window.

---
 rtl/stddev_sqrt_iter_if.sv | 39 +++
 rtl/stddev_sqrt_iter.sv | 119 +++++++++++
 tb/tb_stddev_sqrt_iter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stddev_sqrt_iter_if.sv
// Handshake bundle between the window statistics stage, the square-root stage and the
// cascade evaluator: radicand/tag in, standard deviation/tag out.
interface stddev_sqrt_iter_if #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned TAG_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_var;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_std_dev;
    logic [TAG_WIDTH-1:0] out_tag;

    // Root stage side
    modport slave (
        input  in_valid,
        input  in_var,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_std_dev,
        output out_tag
    );

    // Producer/consumer side
    modport master (
        output in_valid,
        output in_var,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_std_dev,
        input  out_tag
    );
endinterface

// File: rtl/stddev_sqrt_iter.sv
// Multi-cycle integer square root of the window variance term. Restoring algorithm
// consuming two radicand bits per cycle; the window tag rides along untouched.
module stddev_sqrt_iter #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned TAG_WIDTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    stddev_sqrt_iter_if.slave bus
);

    localparam int unsigned Half = IN_WIDTH / 2;
    localparam int unsigned RemW = Half + 2;
    localparam int unsigned CntW = (Half > 1) ? $clog2(Half) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IN_WIDTH-1:0]  v_q, v_d;
    logic [RemW-1:0]      r_q, r_d;
    logic [Half-1:0]      q_q, q_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [TAG_WIDTH-1:0] otag_q, otag_d;
    logic [31:0]          std_q, std_d;

    // One restoring step: bring down the next bit pair and try to subtract 4Q+1.
    logic [RemW-1:0] r_shift;
    logic [RemW-1:0] trial;
    logic [RemW-1:0] diff;
    logic            fits;
    logic [Half:0]   q_wide;
    logic [Half-1:0] q_next;

    // Datapath for a single iteration
    always_comb begin
        // Upper bits of R are zero here (R <= 2Q), so dropping them on the shift is lossless.
        r_shift = {r_q[RemW-3:0], v_q[IN_WIDTH-1 -: 2]};
        trial   = {q_q, 2'b01};
        diff    = r_shift - trial;
        fits    = (r_shift >= trial);
        q_wide  = {q_q, fits};
        q_next  = q_wide[Half-1:0];
    end

    // Next-state logic for the IDLE -> CALC -> DONE sequence
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        otag_d  = otag_q;
        std_d   = std_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    v_d     = bus.in_var;
                    tag_d   = bus.in_tag;
                    r_d     = '0;
                    q_d     = '0;
                    cnt_d   = CntW'(Half - 1);
                    state_d = StCalc;
                end
            end
            StCalc: begin
                v_d = {v_q[IN_WIDTH-3:0], 2'b00};
                r_d = fits ? diff : r_shift;
                q_d = q_next;
                if (cnt_q == '0) begin
                    std_d   = 32'(q_next);
                    otag_d  = tag_q;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any in-flight root without producing a result
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            v_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
            otag_q  <= '0;
            std_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            otag_q  <= otag_d;
            std_q   <= std_d;
        end
    end

    // Handshake flags depend on state only, never on the partner's valid/ready
    assign bus.in_ready    = (state_q == StIdle);
    assign bus.out_valid   = (state_q == StDone);
    assign bus.out_std_dev = std_q;
    assign bus.out_tag     = otag_q;

endmodule

// File: tb/tb_stddev_sqrt_iter.sv
// Self-checking bench for stddev_sqrt_iter: directed roots, backpressure, mid-calculation
// reset, back-to-back acceptance and randomised radicands against a floor(sqrt) model.
module tb_stddev_sqrt_iter;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    stddev_sqrt_iter_if #(.IN_WIDTH(32), .TAG_WIDTH(16)) bus ();

    stddev_sqrt_iter #(.IN_WIDTH(32), .TAG_WIDTH(16)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Largest r with r*r <= x, found by testing squares directly.
    function automatic logic [31:0] ref_isqrt(input logic [31:0] x);
        longint unsigned r;
        longint unsigned c;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            c = r | (64'd1 << b);
            if (c * c <= {32'd0, x}) r = c;
        end
        return 32'(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one radicand and return just after the accepting edge.
    task automatic send(input logic [31:0] v, input logic [15:0] t);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL send_ready: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_var   = v;
        bus.in_tag   = t;
        step();
        bus.in_valid = 1'b0;
        bus.in_var   = $urandom;
        bus.in_tag   = 16'($urandom);
    endtask

    // Wait for out_valid, counting cycles since acceptance.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_std_dev !== 32'd0 || bus.out_tag !== 16'd0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b std=%0d tag=%h required 1 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.out_std_dev, bus.out_tag);
        end
    endtask

    task automatic test_directed();
        logic [31:0] vals[5] = '{32'd0, 32'd1000000, 32'd999999, 32'hFFFF_FFFF, 32'h4000_0000};
        logic [31:0] exps[5] = '{32'd0, 32'd1000, 32'd999, 32'h0000_FFFF, 32'd32768};
        logic [15:0] tags[5] = '{16'h0001, 16'h1234, 16'hBEEF, 16'h8001, 16'h7FFE};
        int lat;
        for (int i = 0; i < 5; i++) begin
            send(vals[i], tags[i]);
            wait_valid(lat);
            tests++;
            if (lat !== 16) begin
                fails++;
                $display("FAIL latency[%0d]: got %0d cycles required 16", i, lat);
            end
            tests++;
            if (bus.out_std_dev !== exps[i] || bus.out_tag !== tags[i]) begin
                fails++;
                $display("FAIL directed[%0d]: std=%0d tag=%h required std=%0d tag=%h",
                         i, bus.out_std_dev, bus.out_tag, exps[i], tags[i]);
            end
            handshake();
            tests++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL release[%0d]: out_valid=%b in_ready=%b required 0 1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        send(32'd250000, 16'hC0DE);
        wait_valid(lat);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_std_dev !== 32'd500 ||
                bus.out_tag !== 16'hC0DE || bus.in_ready !== 1'b0) bad++;
            step();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL backpressure_hold: %0d unstable cycles required 0", bad);
        end
        handshake();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_abort();
        int lat;
        int stale;
        send(32'd123456789, 16'hDEAD);
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: in_ready=%b out_valid=%b required 1 0",
                     bus.in_ready, bus.out_valid);
        end
        stale = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid !== 1'b0) stale++;
            step();
        end
        bus.out_ready = 1'b0;
        tests++;
        if (stale != 0) begin
            fails++;
            $display("FAIL abort_stale: %0d valid cycles required 0", stale);
        end
        send(32'd144, 16'h0144);
        wait_valid(lat);
        tests++;
        if (lat !== 16 || bus.out_std_dev !== 32'd12 || bus.out_tag !== 16'h0144) begin
            fails++;
            $display("FAIL abort_next: lat=%0d std=%0d tag=%h required 16 12 0144",
                     lat, bus.out_std_dev, bus.out_tag);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[4] = '{32'd16, 32'd17, 32'd24, 32'd25};
        logic [31:0] exps[4] = '{32'd4, 32'd4, 32'd4, 32'd5};
        int   acc_idx;
        int   res_idx;
        int   cyc;
        int   last_hs;
        logic rdy_pre;
        acc_idx = 0;
        res_idx = 0;
        cyc     = 0;
        last_hs = -10;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_var    = vals[0];
        bus.in_tag    = 16'hB000;
        while (res_idx < 4 && cyc < 200) begin
            rdy_pre = bus.in_ready;
            if (bus.out_valid === 1'b1) begin
                tests++;
                if (bus.out_std_dev !== exps[res_idx] ||
                    bus.out_tag !== 16'(16'hB000 + res_idx)) begin
                    fails++;
                    $display("FAIL b2b_result[%0d]: std=%0d tag=%h required std=%0d tag=%h",
                             res_idx, bus.out_std_dev, bus.out_tag, exps[res_idx],
                             16'(16'hB000 + res_idx));
                end
                last_hs = cyc + 1;
                res_idx++;
            end
            step();
            cyc++;
            if (rdy_pre === 1'b1 && acc_idx < 4) begin
                if (acc_idx > 0) begin
                    tests++;
                    if (cyc - last_hs != 1) begin
                        fails++;
                        $display("FAIL b2b_accept[%0d]: gap=%0d required 1", acc_idx, cyc - last_hs);
                    end
                end
                acc_idx++;
                if (acc_idx < 4) begin
                    bus.in_var = vals[acc_idx];
                    bus.in_tag = 16'(16'hB000 + acc_idx);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tests++;
        if (res_idx != 4 || acc_idx != 4) begin
            fails++;
            $display("FAIL b2b_count: results=%0d accepts=%0d required 4 4", res_idx, acc_idx);
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [15:0] t;
        logic [31:0] e;
        int lat;
        int errs;
        errs = 0;
        for (int i = 0; i < 2000; i++) begin
            v = $urandom;
            if (i % 8 == 0) v[31] = 1'b1;
            t = 16'($urandom);
            e = ref_isqrt(v);
            if ($urandom_range(0, 3) == 0) step();
            send(v, t);
            wait_valid(lat);
            for (int k = $urandom_range(0, 3); k > 0; k--) step();
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_std_dev !== e || bus.out_tag !== t) begin
                fails++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d] var=%h: valid=%b std=%0d tag=%h required 1 %0d %h",
                             i, v, bus.out_valid, bus.out_std_dev, bus.out_tag, e, t);
            end
            handshake();
        end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_var    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
